// File: rtl/riptide_pkg.sv
// riptide_pkg
// Shared definitions for the interrupt controller:
//   - register offsets inside the 4-byte IO window
//   - reset values of the MASK and EDGE registers
//   - FSM state encoding for the request handshake
//   - candidate record and priority picker (bit 0 highest priority)
package riptide_pkg;

  localparam int NUM_IRQ = 8;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_ACK  = 2'd2;
  localparam logic [1:0] REG_EDGE = 2'd3;

  localparam logic [7:0] MASK_RESET = 8'h00;
  localparam logic [7:0] EDGE_RESET = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } irq_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] index;
  } irq_cand_t;

  // Scans from the top down so the lowest set bit is the last one written,
  // which gives bit 0 the highest priority.
  function automatic irq_cand_t pick_candidate(input logic [NUM_IRQ-1:0] active);
    irq_cand_t cand;
    cand.valid = 1'b0;
    cand.index = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        cand.valid = 1'b1;
        cand.index = 3'(i);
      end
    end
    return cand;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync
// Brings asynchronous interrupt lines into the clk domain and flags rising
// edges. Each bit has two synchronizer flops followed by a previous-value
// flop; all three clear on reset, so a line already high at reset release
// shows up as a rising edge.
// Ports:
//   clk       - rising-edge clock
//   n_reset   - synchronous active-low reset
//   irq_raw   - asynchronous interrupt lines
//   irq_level - synchronized level of each line
//   irq_rise  - one-cycle pulse on a synchronized 0->1 transition
import riptide_pkg::*;

module irq_sync #(
  parameter int WIDTH = NUM_IRQ
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] irq_raw,
  output logic [WIDTH-1:0] irq_level,
  output logic [WIDTH-1:0] irq_rise
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      meta  <= '0;
      level <= '0;
      prev  <= '0;
    end else begin
      meta  <= irq_raw;
      level <= meta;
      prev  <= level;
    end
  end

  assign irq_level = level;
  assign irq_rise  = level & ~prev;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller
// Eight-source prioritised interrupt controller with an IO-mapped register
// window of four byte registers at BASE_ADDR..BASE_ADDR+3:
//   +0 PEND (read-only), +1 MASK (R/W), +2 ACK (write-only), +3 EDGE (R/W)
// A request to the CPU is raised on int_rq with its vector on int_addr and
// held until the CPU acknowledges that vector; afterwards int_rq stays low
// for GAP_CYCLES cycles so the CPU always sees a fresh rising edge.
// Ports:
//   clk, n_reset - clock and synchronous active-low reset
//   irq_in       - asynchronous interrupt sources, bit 0 highest priority
//   address      - CPU IO address
//   data_out     - CPU write data
//   IO_WC        - one-cycle IO write strobe
//   IO_RC        - IO read enable
//   IO_n_LB_w    - write byte select (0: data_out[15:8], 1: data_out[7:0])
//   rd_data      - read data, byte replicated, zero when not selected
//   int_rq       - interrupt request to the CPU
//   int_addr     - vector index, stable while int_rq is high
module interrupt_controller
  import riptide_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  irq_in,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  input  logic        IO_WC,
  input  logic        IO_RC,
  input  logic        IO_n_LB_w,
  output logic [15:0] rd_data,
  output logic        int_rq,
  output logic [2:0]  int_addr
);

  // The counter is loaded with one less than the gap length because the
  // cycle in which it reaches zero is itself a low cycle.
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [15:0] offset;
  logic        in_range;
  logic [1:0]  reg_sel;
  logic [7:0]  wr_byte;
  logic        wr_en;
  logic [7:0]  ack_bits;

  logic [7:0]  irq_level;
  logic [7:0]  irq_rise;

  logic [7:0]  pend;
  logic [7:0]  pend_next;
  logic [7:0]  mask_reg;
  logic [7:0]  edge_mode;

  irq_cand_t   cand;
  logic        ack_hit;

  irq_state_t  state;
  irq_state_t  state_next;
  logic        int_rq_next;
  logic [2:0]  int_addr_next;
  logic [3:0]  gap_cnt;
  logic [3:0]  gap_cnt_next;

  logic [7:0]  rd_byte;

  // Address decode: the subtraction wraps, so only the four addresses
  // starting at BASE_ADDR leave the upper offset bits clear.
  assign offset   = address - BASE_ADDR;
  assign in_range = (offset[15:2] == 14'd0);
  assign reg_sel  = offset[1:0];
  assign wr_byte  = IO_n_LB_w ? data_out[7:0] : data_out[15:8];
  assign wr_en    = IO_WC & in_range;
  assign ack_bits = (wr_en && reg_sel == REG_ACK) ? wr_byte : 8'h00;

  irq_sync #(
    .WIDTH (NUM_IRQ)
  ) u_irq_sync (
    .clk       (clk),
    .n_reset   (n_reset),
    .irq_raw   (irq_in),
    .irq_level (irq_level),
    .irq_rise  (irq_rise)
  );

  // Edge sources latch a rising edge until acknowledged, and a new edge in
  // the same cycle as an ACK wins. Level sources simply follow the
  // synchronized input and ignore ACK.
  always_comb begin
    pend_next = (edge_mode & ((pend & ~ack_bits) | irq_rise)) |
                (~edge_mode & irq_level);
  end

  // Software-visible registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      pend      <= 8'h00;
      mask_reg  <= MASK_RESET;
      edge_mode <= EDGE_RESET;
    end else begin
      pend <= pend_next;
      if (wr_en && reg_sel == REG_MASK) begin
        mask_reg <= wr_byte;
      end
      if (wr_en && reg_sel == REG_EDGE) begin
        edge_mode <= wr_byte;
      end
    end
  end

  assign cand    = pick_candidate(pend & mask_reg);
  assign ack_hit = ack_bits[int_addr];

  // Request FSM state and its registered outputs.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= ST_IDLE;
      int_rq   <= 1'b0;
      int_addr <= 3'd0;
      gap_cnt  <= 4'd0;
    end else begin
      state    <= state_next;
      int_rq   <= int_rq_next;
      int_addr <= int_addr_next;
      gap_cnt  <= gap_cnt_next;
    end
  end

  // Next-state logic. Once in REQ only an ACK of the vector being presented
  // ends the request; masking or clearing the source is deliberately
  // ignored so the CPU never sees a request vanish under it.
  always_comb begin
    state_next    = state;
    int_rq_next   = int_rq;
    int_addr_next = int_addr;
    gap_cnt_next  = gap_cnt;
    case (state)
      ST_IDLE: begin
        int_rq_next = 1'b0;
        if (cand.valid) begin
          state_next    = ST_REQ;
          int_rq_next   = 1'b1;
          int_addr_next = cand.index;
        end
      end
      ST_REQ: begin
        if (ack_hit) begin
          state_next   = ST_GAP;
          int_rq_next  = 1'b0;
          gap_cnt_next = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) begin
          if (cand.valid) begin
            state_next    = ST_REQ;
            int_rq_next   = 1'b1;
            int_addr_next = cand.index;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt - 4'd1;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        int_rq_next = 1'b0;
      end
    endcase
  end

  // Read mux. Zero when not selected so several IO devices can be ORed.
  always_comb begin
    rd_byte = 8'h00;
    case (reg_sel)
      REG_PEND: rd_byte = pend;
      REG_MASK: rd_byte = mask_reg;
      REG_EDGE: rd_byte = edge_mode;
      default:  rd_byte = 8'h00;
    endcase
    rd_data = (IO_RC && in_range) ? {rd_byte, rd_byte} : 16'h0000;
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller
// Directed self-checking bench for interrupt_controller with default
// parameters (BASE_ADDR 16'hFF00, GAP_CYCLES 2). Inputs change 1 ns after
// each rising edge and outputs are sampled there too.
module tb_interrupt_controller;
  import riptide_pkg::*;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk;
  logic        n_reset;
  logic [7:0]  irq_in;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        IO_WC;
  logic        IO_RC;
  logic        IO_n_LB_w;
  logic [15:0] rd_data;
  logic        int_rq;
  logic [2:0]  int_addr;

  int checkCount = 0;
  int passCount  = 0;

  interrupt_controller #(
    .BASE_ADDR  (BASE),
    .GAP_CYCLES (2)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .irq_in    (irq_in),
    .address   (address),
    .data_out  (data_out),
    .IO_WC     (IO_WC),
    .IO_RC     (IO_RC),
    .IO_n_LB_w (IO_n_LB_w),
    .rd_data   (rd_data),
    .int_rq    (int_rq),
    .int_addr  (int_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] irq, input int cycles);
    irq_in = irq;
    step(cycles);
  endtask

  // The unselected byte carries the complement so a wrong byte select shows.
  task automatic ioWrite(input logic [1:0] off, input logic [7:0] val, input logic hi_byte);
    address   = BASE + 16'(off);
    data_out  = hi_byte ? {val, ~val} : {~val, val};
    IO_n_LB_w = ~hi_byte;
    IO_WC     = 1'b1;
    step(1);
    IO_WC     = 1'b0;
    IO_n_LB_w = 1'b1;
    address   = 16'h0000;
    data_out  = 16'h0000;
  endtask

  task automatic readRaw(input logic [15:0] addr, input logic rc, output logic [15:0] val);
    address = addr;
    IO_RC   = rc;
    #1;
    val     = rd_data;
    IO_RC   = 1'b0;
    address = 16'h0000;
  endtask

  task automatic checkReg(input string tag, input logic [1:0] off, input logic [7:0] exp);
    logic [15:0] val;
    readRaw(BASE + 16'(off), 1'b1, val);
    checkOutput(tag, val, {exp, exp});
  endtask

  task automatic checkRq(input string tag, input logic exp);
    checkOutput(tag, {15'd0, int_rq}, {15'd0, exp});
  endtask

  task automatic checkAddr(input string tag, input logic [2:0] exp);
    checkOutput(tag, {13'd0, int_addr}, {13'd0, exp});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [15:0] val;

    n_reset   = 1'b0;
    irq_in    = 8'h00;
    address   = 16'h0000;
    data_out  = 16'h0000;
    IO_WC     = 1'b0;
    IO_RC     = 1'b0;
    IO_n_LB_w = 1'b1;
    step(3);

    // Reset state
    checkRq("rst_rq", 1'b0);
    checkAddr("rst_addr", 3'd0);
    checkReg("rst_pend", REG_PEND, 8'h00);
    checkReg("rst_mask", REG_MASK, 8'h00);
    checkReg("rst_edge", REG_EDGE, 8'hFF);
    n_reset = 1'b1;
    step(2);

    // Single edge source, latency and ACK
    ioWrite(REG_MASK, 8'h04, 1'b0);
    applyStimulus(8'h04, 1);
    applyStimulus(8'h00, 2);
    checkRq("lat_rq_e2", 1'b0);
    checkReg("lat_pend_e2", REG_PEND, 8'h04);
    step(1);
    checkRq("lat_rq_e3", 1'b1);
    checkAddr("lat_addr", 3'd2);
    ioWrite(REG_ACK, 8'h04, 1'b0);
    checkRq("ack2_rq", 1'b0);
    checkReg("ack2_pend", REG_PEND, 8'h00);
    step(4);
    checkRq("ack2_idle", 1'b0);

    // Two sources together, priority and gap length; MASK via upper byte
    ioWrite(REG_MASK, 8'hFF, 1'b1);
    checkReg("mask_hi", REG_MASK, 8'hFF);
    applyStimulus(8'h22, 1);
    applyStimulus(8'h00, 2);
    step(1);
    checkRq("pri_rq", 1'b1);
    checkAddr("pri_addr1", 3'd1);
    checkReg("pri_pend", REG_PEND, 8'h22);
    ioWrite(REG_ACK, 8'h02, 1'b0);
    checkRq("gap_rq0", 1'b0);
    step(1);
    checkRq("gap_rq1", 1'b0);
    step(1);
    checkRq("gap_rq2", 1'b1);
    checkAddr("pri_addr5", 3'd5);
    ioWrite(REG_ACK, 8'h20, 1'b0);
    checkRq("ack5_rq", 1'b0);
    step(3);
    checkRq("ack5_idle", 1'b0);
    checkReg("ack5_pend", REG_PEND, 8'h00);

    // Level source
    ioWrite(REG_EDGE, 8'h00, 1'b0);
    ioWrite(REG_MASK, 8'h01, 1'b0);
    checkReg("lvl_edge", REG_EDGE, 8'h00);
    applyStimulus(8'h01, 4);
    checkRq("lvl_rq", 1'b1);
    checkAddr("lvl_addr", 3'd0);
    ioWrite(REG_ACK, 8'h01, 1'b0);
    checkRq("lvl_ack_rq", 1'b0);
    checkReg("lvl_ack_pend", REG_PEND, 8'h01);
    step(1);
    checkRq("lvl_gap_rq", 1'b0);
    step(1);
    checkRq("lvl_re_rq", 1'b1);
    checkAddr("lvl_re_addr", 3'd0);
    applyStimulus(8'h00, 1);
    checkReg("lvl_drop1", REG_PEND, 8'h01);
    step(2);
    checkReg("lvl_drop3", REG_PEND, 8'h00);
    checkRq("lvl_held_rq", 1'b1);
    ioWrite(REG_ACK, 8'h01, 1'b0);
    step(3);
    checkRq("lvl_idle", 1'b0);
    ioWrite(REG_EDGE, 8'hFF, 1'b0);
    checkReg("edge_back", REG_PEND, 8'h00);

    // Request held through masking and foreign ACK
    ioWrite(REG_MASK, 8'h08, 1'b0);
    applyStimulus(8'h08, 1);
    applyStimulus(8'h00, 3);
    checkRq("hold_rq", 1'b1);
    checkAddr("hold_addr", 3'd3);
    ioWrite(REG_MASK, 8'h00, 1'b0);
    checkRq("hold_masked", 1'b1);
    checkAddr("hold_addr2", 3'd3);
    ioWrite(REG_ACK, 8'h01, 1'b0);
    checkRq("hold_wrong_ack", 1'b1);
    ioWrite(REG_ACK, 8'h08, 1'b0);
    checkRq("hold_right_ack", 1'b0);
    step(3);

    // Edge set in the same cycle as an ACK of that bit
    applyStimulus(8'h10, 2);
    ioWrite(REG_ACK, 8'h10, 1'b0);
    applyStimulus(8'h00, 1);
    checkReg("setwins_pend", REG_PEND, 8'h10);
    checkRq("setwins_rq", 1'b0);
    ioWrite(REG_ACK, 8'h10, 1'b0);
    checkReg("setwins_clr", REG_PEND, 8'h00);

    // Reset mid-request, edge at release, address window
    ioWrite(REG_MASK, 8'h01, 1'b0);
    applyStimulus(8'h01, 1);
    applyStimulus(8'h00, 3);
    checkRq("prerst_rq", 1'b1);
    irq_in  = 8'h02;
    n_reset = 1'b0;
    step(1);
    checkRq("midrst_rq", 1'b0);
    checkAddr("midrst_addr", 3'd0);
    checkReg("midrst_mask", REG_MASK, 8'h00);
    checkReg("midrst_edge", REG_EDGE, 8'hFF);
    checkReg("midrst_pend", REG_PEND, 8'h00);
    n_reset = 1'b1;
    step(3);
    checkReg("rel_edge_pend", REG_PEND, 8'h02);
    checkRq("rel_edge_rq", 1'b0);
    ioWrite(REG_ACK, 8'h02, 1'b0);
    checkReg("rel_ack_pend", REG_PEND, 8'h00);
    irq_in = 8'h00;
    ioWrite(REG_MASK, 8'h5A, 1'b0);
    readRaw(BASE + 16'd4, 1'b1, val);
    checkOutput("oor_above", val, 16'h0000);
    readRaw(BASE - 16'd1, 1'b1, val);
    checkOutput("oor_below", val, 16'h0000);
    readRaw(BASE + 16'd1, 1'b0, val);
    checkOutput("no_rc", val, 16'h0000);
    readRaw(BASE + 16'd1, 1'b1, val);
    checkOutput("mask_5a", val, 16'h5A5A);
    checkReg("ack_reads0", REG_ACK, 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF00, meaning the IO address of register 0; registers occupy BASE_ADDR+0..+3.
REQ-002 Parameter GAP_CYCLES, default 2, meaning the minimum number of low cycles on int_rq between two requests (range 1..15).
REQ-003 clk  input  1  meaning the single clock; all flops are on its rising edge.
REQ-004 n_reset  input  1  meaning the reset; it is synchronous and active-low.
REQ-005 irq_in  input  8  meaning asynchronous interrupt sources; bit 0 has the highest priority.
REQ-006 address  input  16  meaning the CPU IO data address.
REQ-007 data_out  input  16  meaning the CPU write data.
REQ-008 IO_WC  input  1  meaning high for one cycle per IO write.
REQ-009 IO_RC  input  1  meaning high during an IO read.
REQ-010 IO_n_LB_w  input  1  meaning write byte select: low selects data_out[15:8], high selects data_out[7:0].
REQ-011 rd_data  output  16  meaning read data, with the selected register byte replicated in both halves; it is 16'h0000 when not selected.
REQ-012 int_rq  output  1  meaning the interrupt request to the CPU; the CPU acts on its rising edge.
REQ-013 int_addr  output  3  meaning the vector index of the request; it is stable while int_rq is high.

Function
REQ-014 Registers are decoded as follows: offset 0 is PEND (read-only), 1 is MASK (R/W), 2 is ACK (write-only, reads 0), and 3 is EDGE (R/W, where 1 means edge-triggered and 0 means level-triggered).
REQ-015 A write is the cycle with IO_WC=1 and address in range; the byte written is chosen by IO_n_LB_w.
REQ-016 rd_data is combinational from address whenever IO_RC=1 and address is in range; otherwise it is zero, so it can be OR-combined with other IO devices.
REQ-017 Each irq_in bit passes through a 2-flop synchronizer and then a previous-value flop, which together form the sync stage.
REQ-018 An edge source sets its PEND bit on a synchronized 0->1 transition; it is cleared only by an ACK write with a 1 in that bit.
REQ-019 For a level source, the PEND bit equals the synchronized input; ACK writes do not affect it.
REQ-020 When an edge set and an ACK clear hit the same bit in the same cycle, the set wins.
REQ-021 The candidate is the lowest index i with PEND[i] & MASK[i].
REQ-022 The FSM has three states: IDLE, REQ and GAP.
REQ-023 IDLE -> REQ occurs when a candidate exists; int_addr latches the candidate and int_rq goes to 1, both as registered outputs.
REQ-024 In REQ, int_addr is frozen; masking, clearing or dropping the source does not deassert int_rq.
REQ-025 REQ -> GAP occurs on an ACK write whose bit [int_addr] is 1; int_rq goes to 0 on that edge. An ACK write without that bit keeps the FSM in REQ.
REQ-026 GAP holds int_rq low for exactly GAP_CYCLES cycles and then goes to REQ if a candidate exists, otherwise to IDLE.
REQ-027 Latency: if irq_in is high at edge E0 and the source is enabled and the FSM is in IDLE, then PEND is set after E2 and int_rq is high after E3.
REQ-028 A new PEND bit arriving while the FSM is in REQ or GAP is held; it is not lost and not merged.
REQ-029 Writes to MASK and EDGE take effect on the next edge; changing EDGE from 0 to 1 does not by itself create a pending bit.

Reset
REQ-030 When n_reset is sampled low, the block sets: FSM=IDLE, int_rq=0, int_addr=0, PEND=0, MASK=8'h00, EDGE=8'hFF, all sync flops=0 and the GAP counter=0.
REQ-031 Reset asserted mid-request drops int_rq on the same edge.
REQ-032 A source that is high at reset release registers as an edge.
REQ-033 rd_data is combinational and is unaffected by reset except through the register values.

Structure
REQ-034 The shared package riptide_pkg holds the register offsets (PEND/MASK/ACK/EDGE) and the FSM state encoding.
REQ-035 A single sub-module irq_sync, instantiated 8 times or as an 8-wide vector, implements the 2-flop synchronizer plus rising-edge detect.
REQ-036 The target size is 150-250 lines of RTL.

Verification
REQ-037 Set MASK=8'h04 and pulse irq_in[2] for 1 cycle -> int_rq rises 4 edges later with int_addr=2; ACK write 8'h04 -> int_rq goes low and PEND reads 8'h00.
REQ-038 Set MASK=8'hFF and raise irq_in[5] and irq_in[1] together -> int_addr=1 first; after ACK 8'h02, int_rq stays low for exactly 2 cycles, then rises with int_addr=5.
REQ-039 Set EDGE=8'h00, MASK=8'h01 and hold irq_in[0] high -> request is issued; ACK 8'h01 -> after the gap, the request reasserts with int_addr=0; drop irq_in -> PEND bit 0 reads 0 after 3 edges.
REQ-040 In REQ with int_addr=3, write MASK=8'h00 -> int_rq stays 1; an ACK write 8'h01 leaves int_rq at 1; an ACK write 8'h08 deasserts it.
REQ-041 Issue an edge set on bit 4 in the same cycle as an ACK write 8'h10 -> PEND reads 8'h10 afterwards.
REQ-042 Assert n_reset low while int_rq=1 -> after that edge, int_rq=0, MASK reads 8'h00 and EDGE reads 8'hFF; a read outside BASE_ADDR..+3 returns rd_data=16'h0000.
